// File: rtl/ptos_pkg.sv
// Shared definitions for the two-lane paratoserial scheduler.
// State encoding, default COM symbol and serial slot length.
package ptos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int         SLOT_LEN    = 8;
  localparam logic [7:0] COM_SYM_DEF = 8'hBC;

endpackage

// File: rtl/ptos_slot_counter.sv
// Free-running 3-bit serial slot counter (0..7, wraps).
// Ports: i_clk, i_rst (async high), o_cnt, o_slot_start (cnt==0), o_boundary (cnt==7).
module ptos_slot_counter
  import ptos_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [2:0] o_cnt,
  output logic       o_slot_start,
  output logic       o_boundary
);

  logic [2:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= r_cnt + 3'd1;
  end

  assign o_cnt        = r_cnt;
  assign o_slot_start = (r_cnt == 3'd0);
  assign o_boundary   = (r_cnt == 3'(SLOT_LEN - 1));

endmodule

// File: rtl/ptos_lane_scheduler.sv
// Stripes a byte stream over two serializer lanes, runs COM training.
// Ports: clk, reset, enable, lane_mode, up_* handshake, in0/in1/valid_*, slot_start, state.
module ptos_lane_scheduler
  import ptos_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                TRAIN_SLOTS = 4,
  parameter logic [DATA_W-1:0] COM_SYM     = DATA_W'(COM_SYM_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              lane_mode,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_valid,
  output logic              up_ready,
  output logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] in1,
  output logic              valid_0,
  output logic              valid_1,
  output logic              slot_start,
  output logic [1:0]        state
);

  logic [2:0]        w_cnt;
  logic              w_bnd;
  logic              w_full;
  logic              w_acc;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_train_cnt;
  logic              r_mode;
  logic [DATA_W-1:0] r_s0;
  logic [DATA_W-1:0] r_s1;
  logic              r_f0;
  logic              r_f1;
  logic [DATA_W-1:0] r_in0;
  logic [DATA_W-1:0] r_in1;
  logic              r_v0;
  logic              r_v1;

  ptos_slot_counter u_cnt (
    .i_clk        (clk),
    .i_rst        (reset),
    .o_cnt        (w_cnt),
    .o_slot_start (slot_start),
    .o_boundary   (w_bnd)
  );

  assign w_full   = r_mode ? (r_f0 & r_f1) : r_f0;
  // Never ready on the boundary cycle, so accept and unload cannot collide.
  assign up_ready = (r_state == ST_ACTIVE)
                 && (w_cnt != 3'(SLOT_LEN - 1))
                 && !w_full;
  assign w_acc    = up_valid && up_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_bnd) begin
      if (!enable) begin
        w_state_nxt = ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE:   w_state_nxt = ST_TRAIN;
          // Leave once the final COM slot is already on the wire.
          ST_TRAIN:  if (r_train_cnt <= 4'd1) w_state_nxt = ST_ACTIVE;
          ST_ACTIVE: w_state_nxt = ST_ACTIVE;
          default:   w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_train_cnt <= '0;
      r_mode      <= 1'b0;
    end else if (w_bnd) begin
      r_mode <= lane_mode;
      if (w_state_nxt == ST_IDLE)
        r_train_cnt <= '0;
      else if (r_state == ST_IDLE)
        r_train_cnt <= 4'(TRAIN_SLOTS);
      else if (r_state == ST_TRAIN && r_train_cnt != 4'd0)
        r_train_cnt <= r_train_cnt - 4'd1;
    end
  end

  // Staging empties every boundary; fill pointer is simply !r_f0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_f0 <= 1'b0;
      r_f1 <= 1'b0;
    end else if (w_bnd) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_f0 <= 1'b0;
      r_f1 <= 1'b0;
    end else if (w_acc) begin
      if (!r_f0) begin
        r_s0 <= up_data;
        r_f0 <= 1'b1;
      end else begin
        r_s1 <= up_data;
        r_f1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in0 <= '0;
      r_in1 <= '0;
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
    end else if (w_bnd) begin
      unique case (w_state_nxt)
        ST_TRAIN: begin
          r_in0 <= COM_SYM;
          r_v0  <= 1'b1;
          r_in1 <= lane_mode ? COM_SYM : '0;
          r_v1  <= lane_mode;
        end
        ST_ACTIVE: begin
          r_in0 <= r_f0 ? r_s0 : '0;
          r_v0  <= r_f0;
          r_in1 <= r_f1 ? r_s1 : '0;
          r_v1  <= r_f1;
        end
        default: begin
          r_in0 <= '0;
          r_in1 <= '0;
          r_v0  <= 1'b0;
          r_v1  <= 1'b0;
        end
      endcase
    end
  end

  assign in0     = r_in0;
  assign in1     = r_in1;
  assign valid_0 = r_v0;
  assign valid_1 = r_v1;
  assign state   = r_state;

endmodule

// File: tb/tb_ptos_lane_scheduler.sv
// Directed bench for ptos_lane_scheduler.
// Walks reset, training, striping, partial slots, mode 0 and async reset.
module tb_ptos_lane_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       lane_mode;
  logic [7:0] up_data;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       valid_0;
  logic       valid_1;
  logic       slot_start;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ptos_lane_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lane_mode  (lane_mode),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .in0        (in0),
    .in1        (in1),
    .valid_0    (valid_0),
    .valid_1    (valid_1),
    .slot_start (slot_start),
    .state      (state)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic exp_ss;
    reset = 1'b1; enable = 1'b0; lane_mode = 1'b0;
    up_valid = 1'b0; up_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in0, in1, valid_0, valid_1, up_ready} !== 19'd0) begin
      errors++;
      $display("FAIL rst_outs got %h want 0",
               {in0, in1, valid_0, valid_1, up_ready});
    end
    checks++;
    if (slot_start !== 1'b1 || state !== 2'd0) begin
      errors++;
      $display("FAIL rst_ss_state got %b/%0d want 1/0", slot_start, state);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_ss = (i % 8 == 0);
      checks++;
      if (slot_start !== exp_ss || state !== 2'd0 || valid_0 !== 1'b0) begin
        errors++;
        $display("FAIL idle_cyc%0d got ss=%b st=%0d v0=%b want ss=%b st=0 v0=0",
                 i, slot_start, state, valid_0, exp_ss);
      end
      tick(1);
    end
  endtask

  task automatic test_train;
    enable = 1'b1; lane_mode = 1'b1;
    tick(8);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (state !== 2'd1 || in0 !== 8'hBC || in1 !== 8'hBC ||
          valid_0 !== 1'b1 || valid_1 !== 1'b1 || up_ready !== 1'b0) begin
        errors++;
        $display("FAIL train_slot%0d got st=%0d %h/%h v=%b%b rdy=%b want 1 bc/bc 11 0",
                 s, state, in0, in1, valid_0, valid_1, up_ready);
      end
      tick(8);
    end
    checks++;
    if (state !== 2'd2 || valid_0 !== 1'b0 || valid_1 !== 1'b0 || in0 !== 8'h00) begin
      errors++;
      $display("FAIL train_exit got st=%0d v=%b%b in0=%h want 2 00 00",
               state, valid_0, valid_1, in0);
    end
  endtask

  task automatic test_mode1_pair;
    checks++;
    if (up_ready !== 1'b1) begin
      errors++;
      $display("FAIL pair_rdy0 got %b want 1", up_ready);
    end
    up_valid = 1'b1; up_data = 8'hAA;
    tick(1);
    checks++;
    if (up_ready !== 1'b1) begin
      errors++;
      $display("FAIL pair_rdy1 got %b want 1", up_ready);
    end
    up_data = 8'hBB;
    tick(1);
    up_data = 8'hCC;
    for (int c = 2; c < 8; c++) begin
      checks++;
      if (up_ready !== 1'b0) begin
        errors++;
        $display("FAIL pair_block_cnt%0d got %b want 0", c, up_ready);
      end
      tick(1);
    end
    checks++;
    if (in0 !== 8'hAA || in1 !== 8'hBB || valid_0 !== 1'b1 || valid_1 !== 1'b1) begin
      errors++;
      $display("FAIL pair_out got %h/%h v=%b%b want aa/bb 11",
               in0, in1, valid_0, valid_1);
    end
    checks++;
    if (up_ready !== 1'b1) begin
      errors++;
      $display("FAIL pair_rdy_next got %b want 1", up_ready);
    end
    up_valid = 1'b0;
    tick(7);
    checks++;
    if (in0 !== 8'hAA || in1 !== 8'hBB || valid_1 !== 1'b1) begin
      errors++;
      $display("FAIL pair_stable got %h/%h v1=%b want aa/bb 1", in0, in1, valid_1);
    end
    tick(1);
  endtask

  task automatic test_partial;
    checks++;
    if (valid_0 !== 1'b0 || valid_1 !== 1'b0 || in0 !== 8'h00) begin
      errors++;
      $display("FAIL empty_slot got v=%b%b in0=%h want 00 00", valid_0, valid_1, in0);
    end
    up_valid = 1'b1; up_data = 8'h5A;
    tick(1);
    up_valid = 1'b0;
    tick(7);
    checks++;
    if (in0 !== 8'h5A || valid_0 !== 1'b1 || valid_1 !== 1'b0 || in1 !== 8'h00) begin
      errors++;
      $display("FAIL partial_out got %h/%h v=%b%b want 5a/00 10",
               in0, in1, valid_0, valid_1);
    end
    tick(8);
    checks++;
    if (valid_0 !== 1'b0 || valid_1 !== 1'b0 || in0 !== 8'h00) begin
      errors++;
      $display("FAIL partial_after got v=%b%b in0=%h want 00 00", valid_0, valid_1, in0);
    end
    lane_mode = 1'b0;
    tick(8);
  endtask

  task automatic test_mode0;
    up_valid = 1'b1; up_data = 8'h11;
    tick(1);
    checks++;
    if (up_ready !== 1'b0) begin
      errors++;
      $display("FAIL m0_block got %b want 0", up_ready);
    end
    up_data = 8'h22;
    tick(6);
    checks++;
    if (up_ready !== 1'b0) begin
      errors++;
      $display("FAIL m0_block_late got %b want 0", up_ready);
    end
    tick(1);
    checks++;
    if (in0 !== 8'h11 || valid_0 !== 1'b1 || valid_1 !== 1'b0 || in1 !== 8'h00) begin
      errors++;
      $display("FAIL m0_out got %h/%h v=%b%b want 11/00 10",
               in0, in1, valid_0, valid_1);
    end
    up_valid = 1'b0;
    tick(8);
    checks++;
    if (valid_0 !== 1'b0 || in0 !== 8'h00) begin
      errors++;
      $display("FAIL m0_no_leak got v0=%b in0=%h want 0 00", valid_0, in0);
    end
  endtask

  task automatic test_disable_reset;
    up_valid = 1'b1; up_data = 8'h77;
    tick(1);
    up_valid = 1'b0;
    enable = 1'b0;
    tick(7);
    checks++;
    if (state !== 2'd0 || valid_0 !== 1'b0 || in0 !== 8'h00 || up_ready !== 1'b0) begin
      errors++;
      $display("FAIL dis_idle got st=%0d v0=%b in0=%h rdy=%b want 0 0 00 0",
               state, valid_0, in0, up_ready);
    end
    enable = 1'b1; lane_mode = 1'b1;
    tick(8);
    checks++;
    if (state !== 2'd1 || in0 !== 8'hBC || valid_1 !== 1'b1) begin
      errors++;
      $display("FAIL retrain got st=%0d in0=%h v1=%b want 1 bc 1", state, in0, valid_1);
    end
    tick(3);
    reset = 1'b1;
    #2;
    checks++;
    if ({in0, in1, valid_0, valid_1} !== 18'd0 || state !== 2'd0 ||
        slot_start !== 1'b1 || up_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got %h/%h v=%b%b st=%0d ss=%b want 00/00 00 0 1",
               in0, in1, valid_0, valid_1, state, slot_start);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_train();
    test_mode1_pair();
    test_partial();
    test_mode0();
    test_disable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
